// File: rtl/dma_path_pkg.sv
// rtl/dma_path_pkg.sv - shared constants for the DMA path arbiter
// Contents:
//   OP_RD / OP_WR      command opcodes
//   *_LSB / *_MSB      command beat field positions
//   ST_*               arbiter state encoding
package dma_path_pkg;

  localparam int BEAT_W = 128;
  localparam int LEN_W  = 16;

  localparam logic [7:0] OP_RD = 8'h01;
  localparam logic [7:0] OP_WR = 8'h03;

  localparam int OPCODE_MSB = 79;
  localparam int OPCODE_LSB = 72;
  localparam int LEN_MSB    = 71;
  localparam int LEN_LSB    = 56;
  localparam int HADDR_MSB  = 55;
  localparam int HADDR_LSB  = 16;
  localparam int LADDR_MSB  = 11;
  localparam int LADDR_LSB  = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_WR_DATA = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

endpackage

// File: rtl/dma_path_arbiter_rr.sv
// rtl/dma_path_arbiter_rr.sv - combinational round-robin pick
// Ports:
//   req_i        request vector
//   last_i       index of the previous winner (lowest priority)
//   grant_oh_o   one-hot winner, zero when no request
//   grant_idx_o  winner index, zero when no request
module rr_arbiter_n #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]  grant_idx_o
);

  int              cand;
  logic [ID_W-1:0] cand_idx;
  logic            found;

  // Search last+1, last+2, ... wrapping at N_REQ; last itself is tried last.
  always_comb begin
    cand        = 0;
    cand_idx    = '0;
    found       = 1'b0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(last_i) + off) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found                 = 1'b1;
        grant_oh_o[cand_idx]  = 1'b1;
        grant_idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dma_path_arbiter.sv
// rtl/dma_path_arbiter.sv - shares one DMA path port among N_REQ requesters
// Ports:
//   clk, rst                         clock, async active-high reset
//   s_dma_req / s_dma_resp           per-requester request, owner-only response
//   s_write_valid/data/ready         per-requester write beats (data flattened)
//   s_read_valid/data/ready          per-requester read beats (data broadcast)
//   m_dma_req / m_dma_resp           request/response to the DMA path controller
//   m_write_valid/data/ready         muxed write beats
//   m_read_valid/data/ready          read beats from the controller
//   busy, grant_id                   ownership status, current/last owner
//   err_opcode, err_stray_read       one-cycle error pulses
module dma_path_arbiter
  import dma_path_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        s_dma_req,
  output logic [N_REQ-1:0]        s_dma_resp,
  input  logic [N_REQ-1:0]        s_write_valid,
  input  logic [128*N_REQ-1:0]    s_write_data,
  output logic [N_REQ-1:0]        s_write_ready,
  output logic [N_REQ-1:0]        s_read_valid,
  output logic [127:0]            s_read_data,
  input  logic [N_REQ-1:0]        s_read_ready,
  output logic                    m_dma_req,
  input  logic                    m_dma_resp,
  output logic                    m_write_valid,
  output logic [127:0]            m_write_data,
  input  logic                    m_write_ready,
  input  logic                    m_read_valid,
  input  logic [127:0]            m_read_data,
  output logic                    m_read_ready,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic                    err_opcode,
  output logic                    err_stray_read
);

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             req_q, req_d;
  logic             err_op_q, err_op_d;
  logic             err_stray_q, err_stray_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  logic             wr_phase;
  logic             wr_acc;
  logic             rd_acc;
  logic [7:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  rr_arbiter_n #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i       (s_dma_req),
    .last_i      (grant_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx)
  );

  assign pick_any = |pick_oh;

  // Owner routing. The write path is open only while the owner is sending
  // its command or write data; read beats reach the owner only in RD_DATA,
  // otherwise the controller side is always drained (and flagged).
  assign wr_phase = (state_q == ST_CMD) || (state_q == ST_WR_DATA);

  always_comb begin
    m_write_data  = s_write_data[BEAT_W*int'(grant_q) +: BEAT_W];
    m_write_valid = wr_phase && s_write_valid[grant_q];
    s_write_ready = '0;
    if (wr_phase) begin
      s_write_ready[grant_q] = m_write_ready;
    end
    s_dma_resp = '0;
    if (state_q == ST_REQ) begin
      s_dma_resp[grant_q] = m_dma_resp;
    end
    s_read_valid = '0;
    m_read_ready = 1'b1;
    if (state_q == ST_RD_DATA) begin
      s_read_valid[grant_q] = m_read_valid;
      m_read_ready          = s_read_ready[grant_q];
    end
  end

  assign s_read_data = m_read_data;

  assign wr_acc  = m_write_valid && m_write_ready;
  assign rd_acc  = m_read_valid && m_read_ready;
  assign cmd_op  = m_write_data[OPCODE_MSB:OPCODE_LSB];
  assign cmd_len = m_write_data[LEN_MSB:LEN_LSB];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    err_op_d    = 1'b0;
    err_stray_d = rd_acc && (state_q != ST_RD_DATA);
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_dma_resp) begin
          req_d   = 1'b0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (wr_acc) begin
          cnt_d = cmd_len;
          // A bad opcode is reported even with zero length.
          if ((cmd_op != OP_WR) && (cmd_op != OP_RD)) begin
            err_op_d = 1'b1;
            state_d  = ST_RELEASE;
          end else if (cmd_len == '0) begin
            state_d = ST_RELEASE;
          end else if (cmd_op == OP_WR) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d = ST_RD_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (wr_acc) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (cnt_q <= LEN_W'(1)) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RD_DATA: begin
        if (rd_acc) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (cnt_q <= LEN_W'(1)) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        // grant_q is kept so the finished owner ranks last next round.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= ID_W'(N_REQ - 1);
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      cnt_q       <= '0;
      err_op_q    <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      err_op_q    <= err_op_d;
      err_stray_q <= err_stray_d;
    end
  end

  assign m_dma_req      = req_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign err_opcode     = err_op_q;
  assign err_stray_read = err_stray_q;

endmodule

// File: tb/tb_dma_path_arbiter.sv
// tb/tb_dma_path_arbiter.sv - scoreboard bench for dma_path_arbiter
module tb_dma_path_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_dma_req, s_dma_resp;
  logic [N-1:0]   s_write_valid, s_write_ready;
  logic [128*N-1:0] s_write_data;
  logic [N-1:0]   s_read_valid, s_read_ready;
  logic [127:0]   s_read_data;
  logic           m_dma_req, m_dma_resp;
  logic           m_write_valid, m_write_ready;
  logic [127:0]   m_write_data;
  logic           m_read_valid, m_read_ready;
  logic [127:0]   m_read_data;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_opcode, err_stray_read;

  int n_vec = 0;
  int n_miss = 0;
  int wr_acc_cnt = 0;
  int err_op_cnt = 0;
  int stray_cnt = 0;
  bit bp_mode = 1'b0;

  logic [127:0] wr_q[$];
  logic [127:0] rd_q[$];
  int           rd_own[$];

  dma_path_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .s_dma_req(s_dma_req), .s_dma_resp(s_dma_resp),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_write_ready(s_write_ready),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ready(s_read_ready),
    .m_dma_req(m_dma_req), .m_dma_resp(m_dma_resp),
    .m_write_valid(m_write_valid), .m_write_data(m_write_data), .m_write_ready(m_write_ready),
    .m_read_valid(m_read_valid), .m_read_data(m_read_data), .m_read_ready(m_read_ready),
    .busy(busy), .grant_id(grant_id),
    .err_opcode(err_opcode), .err_stray_read(err_stray_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DMA controller: one-cycle response pulse to each request.
  initial begin
    m_dma_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_dma_resp = m_dma_req && !m_dma_resp;
    end
  end

  // Write ready: constant 1, or toggling 1010... in backpressure mode.
  initial begin
    m_write_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) m_write_ready = !m_write_ready;
      else m_write_ready = 1'b1;
    end
  end

  // Controller-side write monitor.
  initial forever begin
    @(negedge clk);
    if (!rst && m_write_valid && m_write_ready) begin
      wr_acc_cnt++;
      if (wr_q.size() == 0) chk("wr_extra", 1, 0);
      else chk("wr_beat", m_write_data, wr_q.pop_front());
    end
  end

  // Requester-side read monitor.
  initial forever begin
    @(negedge clk);
    if (|s_read_valid) begin
      if (rd_q.size() == 0) chk("rd_extra", s_read_valid, 0);
      else if (|(s_read_valid & s_read_ready)) begin
        chk("rd_owner", s_read_valid, 128'(1) << rd_own.pop_front());
        chk("rd_beat", s_read_data, rd_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (err_opcode) err_op_cnt++;
    if (err_stray_read) stray_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic wait_resp(input int own);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = |s_dma_resp;
    end
    if (!seen) chk("resp_timeout", 0, 1);
    else begin
      chk("grant", grant_id, own);
      chk("resp_onehot", s_dma_resp, 128'(1) << own);
      chk("m_dma_req", m_dma_req, 1);
    end
  endtask

  task automatic send_beat(input int own, input logic [127:0] d);
    bit acc = 1'b0;
    s_write_valid[own] = 1'b1;
    s_write_data[128*own +: 128] = d;
    wr_q.push_back(d);
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = s_write_ready[own];
      @(posedge clk); #1;
    end
    s_write_valid[own] = 1'b0;
    if (!acc) chk("wr_timeout", 0, 1);
  endtask

  task automatic rd_beat(input int own, input logic [127:0] d);
    bit acc = 1'b0;
    m_read_valid = 1'b1;
    m_read_data = d;
    s_read_ready[own] = 1'b1;
    rd_q.push_back(d);
    rd_own.push_back(own);
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = m_read_ready;
      @(posedge clk); #1;
    end
    m_read_valid = 1'b0;
    s_read_ready[own] = 1'b0;
    if (!acc) chk("rd_timeout", 0, 1);
  endtask

  function automatic logic [127:0] mk_cmd(input logic [7:0] op, input int len, input logic [127:0] seed);
    logic [127:0] c = '0;
    c[79:72] = op;
    c[71:56] = 16'(len);
    c[55:16] = seed[39:0];
    c[11:0]  = seed[51:40];
    return c;
  endfunction

  // drop: 0 keep request, 1 drop own request, 2 drop all requests.
  task automatic do_txn(input int own, input logic [7:0] op, input int len,
                        input int drop, input logic [127:0] seed);
    wait_resp(own);
    @(posedge clk); #1;
    if (drop == 1) s_dma_req[own] = 1'b0;
    else if (drop == 2) s_dma_req = '0;
    send_beat(own, mk_cmd(op, len, seed));
    if (op == 8'h03) for (int i = 0; i < len; i++) send_beat(own, seed + 128'(i) + 128'h1);
    else if (op == 8'h01) for (int i = 0; i < len; i++) rd_beat(own, ~seed - 128'(i));
    @(negedge clk);
    chk("busy_hold", busy, 1);
    @(negedge clk);
    chk("busy_drop", busy, 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
  endtask

  initial begin
    int acc0;
    rst = 1'b1;
    s_dma_req = '0; s_write_valid = '0; s_write_data = '0; s_read_ready = '0;
    m_read_valid = 1'b0; m_read_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m_dma_req", m_dma_req, 0);
    chk("rst_grant", grant_id, N - 1);
    chk("rst_resp", s_dma_resp, 0);
    chk("rst_wready", s_write_ready, 0);
    chk("rst_rvalid", s_read_valid, 0);
    chk("rst_errs", {err_opcode, err_stray_read}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single write, requester 0, length 3
    @(posedge clk); #1;
    s_dma_req[0] = 1'b1;
    @(negedge clk);
    chk("req_lat_before", m_dma_req, 0);
    acc0 = wr_acc_cnt;
    do_txn(0, 8'h03, 3, 1, 128'hA5A5_0000_1111_2222_3333_4444_5555_0000);
    chk("t1_beats", wr_acc_cnt - acc0, 4);

    // single read, requester 2, length 2
    @(posedge clk); #1;
    s_dma_req[2] = 1'b1;
    do_txn(2, 8'h01, 2, 1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);

    // backpressure write, requester 1, length 4
    @(posedge clk); #1;
    bp_mode = 1'b1;
    s_dma_req[1] = 1'b1;
    acc0 = wr_acc_cnt;
    do_txn(1, 8'h03, 4, 1, 128'hDEAD_BEEF_0000_0000_0000_0000_1000_0000);
    chk("bp_beats", wr_acc_cnt - acc0, 5);
    bp_mode = 1'b0;

    // bad opcode, then a normal grant, then a zero-length write
    @(posedge clk); #1;
    s_dma_req[3] = 1'b1;
    do_txn(3, 8'h07, 2, 1, 128'h77);
    chk("err_opcode_cnt", err_op_cnt, 1);
    @(posedge clk); #1;
    s_dma_req[0] = 1'b1;
    do_txn(0, 8'h03, 1, 1, 128'h9999_0000);
    @(posedge clk); #1;
    s_dma_req[2] = 1'b1;
    acc0 = wr_acc_cnt;
    do_txn(2, 8'h03, 0, 1, 128'h5555);
    chk("len0_beats", wr_acc_cnt - acc0, 1);

    // stray read beat while idle
    @(posedge clk); #1;
    m_read_valid = 1'b1;
    m_read_data = 128'hBAD;
    @(negedge clk);
    chk("stray_ready", m_read_ready, 1);
    chk("stray_no_rvalid", s_read_valid, 0);
    @(posedge clk); #1;
    m_read_valid = 1'b0;
    @(negedge clk);
    chk("stray_pulse", err_stray_read, 1);
    @(negedge clk);
    chk("stray_pulse_end", err_stray_read, 0);
    chk("stray_cnt", stray_cnt, 1);

    // reset in the middle of a length-5 write
    @(posedge clk); #1;
    s_dma_req[0] = 1'b1;
    wait_resp(0);
    @(posedge clk); #1;
    s_dma_req[0] = 1'b0;
    send_beat(0, mk_cmd(8'h03, 5, 128'h42));
    send_beat(0, 128'h1001);
    send_beat(0, 128'h1002);
    s_write_valid[0] = 1'b1;
    s_write_data[127:0] = 128'h1003;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", m_dma_req, 0);
    chk("mid_rst_grant", grant_id, N - 1);
    chk("mid_rst_wvalid", m_write_valid, 0);
    chk("mid_rst_wready", s_write_ready, 0);
    s_write_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // contention: all requesters held, length-1 writes, order 0,1,2,3,0
    @(posedge clk); #1;
    s_dma_req = '1;
    do_txn(0, 8'h03, 1, 0, 128'hC0);
    do_txn(1, 8'h03, 1, 0, 128'hC1);
    do_txn(2, 8'h03, 1, 0, 128'hC2);
    do_txn(3, 8'h03, 1, 0, 128'hC3);
    do_txn(0, 8'h03, 1, 2, 128'hC4);

    repeat (3) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_err_op", err_op_cnt, 1);
    chk("final_stray", stray_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
